hash_arbiter: RTL and testbench
===============================

Name: hash_arbiter

Overview:
- Shares one fullHashDES core between NREQ requesters.
- Grants whole messages round-robin and streams the granted requester's bytes into the core with M_valid/C_in/M.
- Waits for hash_ready, then returns the 32-bit digest to the requester with a one-cycle done pulse.
- Sits between the DMA/requester clients and the single hash core in the crypto subsystem.

Parameters:
- NREQ, 4, number of requesters (2..8).
- LEN_W, 64, message length width; matches core C_in.
- TIMEOUT_CYCLES, 64, WAIT watchdog limit (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  request pending, per requester
- req_len  in  NREQ*LEN_W  message length in bytes, per requester
- req_byte  in  NREQ*8  message byte, per requester
- req_byte_valid  in  NREQ  byte present
- req_byte_ready  out  NREQ  byte consumed this cycle
- req_grant  out  NREQ  one-hot; high from grant through done
- req_done  out  NREQ  one-cycle completion pulse
- req_err  out  NREQ  one-cycle timeout pulse (optional feature only; otherwise tied 0)
- digest  out  32  result of last completed job
- busy  out  1  state != IDLE
- hash_M_valid  out  1  to core M_valid
- hash_C_in  out  LEN_W  to core C_in
- hash_M  out  8  to core M
- hash_ready  in  1  from core
- hash_digest  in  32  from core digest_out

Behaviour:
- Reset (async, rst_n low): state IDLE, rr pointer 0. All outputs 0: req_grant, req_done, req_err, req_byte_ready, digest, busy, hash_M_valid, hash_C_in, hash_M.
- IDLE: if any req_valid, grant the first set bit at or after rr pointer (wrapping). Register grant index g, req_len[g] into hash_C_in and into the remaining-byte counter, assert req_grant[g]. Go to SEND, or to EMPTY if len==0. req_valid and req_len must be stable until grant; sampled only in IDLE.
- EMPTY: drive hash_M_valid=1, hash_M=0 for exactly one cycle, consume no bytes, then go to WAIT.
- SEND: hash_M_valid = req_byte_valid[g]; req_byte_ready[g] = same; hash_M = req_byte[g]. This path is a combinational mux. The remaining-byte counter decrements on each transfer. Gaps (byte_valid low) hold M_valid low. After the last byte transfers, go to WAIT. Non-granted byte_ready stays 0.
- hash_C_in is held constant from grant until exit of DONE, then returns to 0.
- WAIT: ignore hash_ready in the first WAIT cycle (stale result from the previous job). From the second cycle on, hash_ready=1 captures hash_digest into digest and goes to DONE.
- DONE: req_done[g]=1 for one cycle, then req_grant cleared, rr pointer = g+1 mod NREQ, state IDLE. digest holds until the next completion.
- Fairness: a requester re-asserting req_valid immediately is served after all others pending.
- Grant-to-first-M_valid: 1 cycle. Done is 1 cycle after hash_ready is accepted.
- Requester dropping req_valid mid-job: ignored; the job completes for len bytes.
- Length counter is unsigned LEN_W bits; no wrap, since it starts at len ≥ 1 in SEND.

Optional Feature:
- Macro HASH_ARB_TIMEOUT_EN.
- Enabled: a counter runs in WAIT. If TIMEOUT_CYCLES elapse without hash_ready, pulse req_err[g] instead of req_done[g], leave digest unchanged, and return to IDLE with rr advance.
- Disabled: WAIT is unbounded and req_err is constant 0.

Decomposition:
- Package hash_arb_pkg: state enum (IDLE, EMPTY, SEND, WAIT, DONE), LEN_W and digest width constants, and the timeout default.
- One sub-module: rr_arbiter (NREQ request vector + pointer -> one-hot grant and index), purely combinational.

Test Plan:
- Empty message: req_valid[0]=1, len=0 -> one hash_M_valid pulse with C_in=0, no byte_ready, req_done[0] pulse, digest=32'h956F7883.
- Single byte: req 1, len=1, byte 8'd65 -> exactly one transfer, hash_C_in=1 held through DONE, req_done[1] with digest equal to a direct-core run of "A".
- Gapped stream: req 2, len=156, bytes 0..155 with byte_valid toggling 1-0-0 -> digest identical to a contiguous 156-byte run; counter never underflows.
- Round-robin: all 4 req_valid held high, len=3 each -> grant order 0,1,2,3,0; no overlap of req_grant bits.
- Reset mid-SEND: assert rst_n low at byte 100 of a 255-byte job -> all outputs 0 immediately; after release, a new job completes correctly.
- Timeout (HASH_ARB_TIMEOUT_EN): core model never raises hash_ready -> req_err pulses after 64 WAIT cycles, digest unchanged, next requester granted.

Source files
------------

// File: rtl/hash_arb_pkg.sv
// Shared types and defaults for the hash_arbiter block: FSM state encoding,
// core interface widths and the default WAIT watchdog limit.
package hash_arb_pkg;
    localparam int LEN_W_DEF   = 64;
    localparam int DIGEST_W    = 32;
    localparam int TIMEOUT_DEF = 64;

    typedef enum logic [2:0] {
        IDLE,
        EMPTY,
        SEND,
        WAIT,
        DONE
    } state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping, returned both as a one-hot vector and as an index.
module rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int IDX_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);
    always_comb begin
        int j;
        logic [IDX_W-1:0] jj;
        j     = 0;
        jj    = '0;
        idx   = '0;
        any   = |req;
        // Scan from the farthest offset down so the nearest request wins.
        for (int i = NREQ - 1; i >= 0; i--) begin
            j = int'(ptr) + i;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            jj = IDX_W'(j);
            if (req[jj]) begin
                idx = jj;
            end
        end
        grant = any ? (NREQ'(1) << idx) : '0;
    end
endmodule

// File: rtl/hash_arbiter.sv
// Round-robin sharing of one hash core between NREQ requesters, one whole
// message per grant. Define HASH_ARB_TIMEOUT_EN to add a WAIT watchdog (req_err).
module hash_arbiter
    import hash_arb_pkg::*;
#(
    parameter int NREQ           = 4,
    parameter int LEN_W          = LEN_W_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*LEN_W-1:0] req_len,
    input  logic [NREQ*8-1:0]     req_byte,
    input  logic [NREQ-1:0]       req_byte_valid,
    output logic [NREQ-1:0]       req_byte_ready,
    output logic [NREQ-1:0]       req_grant,
    output logic [NREQ-1:0]       req_done,
    output logic [NREQ-1:0]       req_err,
    output logic [DIGEST_W-1:0]   digest,
    output logic                  busy,
    output logic                  hash_M_valid,
    output logic [LEN_W-1:0]      hash_C_in,
    output logic [7:0]            hash_M,
    input  logic                  hash_ready,
    input  logic [DIGEST_W-1:0]   hash_digest
);
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    logic [7:0]       byte_arr [NREQ];
    logic [LEN_W-1:0] len_arr  [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign byte_arr[gi] = req_byte[gi*8 +: 8];
            assign len_arr[gi]  = req_len[gi*LEN_W +: LEN_W];
        end
    endgenerate

    state_t                state_reg;
    logic [IDX_W-1:0]      g_reg;
    logic [IDX_W-1:0]      rr_reg;
    logic [NREQ-1:0]       grant_reg;
    logic [NREQ-1:0]       done_reg;
    logic [NREQ-1:0]       err_reg;
    logic [LEN_W-1:0]      cnt_reg;
    logic [LEN_W-1:0]      c_in_reg;
    logic [DIGEST_W-1:0]   digest_reg;
    logic [TO_W-1:0]       wcnt_reg;

    logic [NREQ-1:0]  arb_grant;
    logic [IDX_W-1:0] arb_idx;
    logic             arb_any;
    logic [LEN_W-1:0] sel_len;
    logic             xfer;
    logic             timeout_hit;

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req   (req_valid),
        .ptr   (rr_reg),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    assign sel_len = len_arr[arb_idx];
    assign xfer    = (state_reg == SEND) && req_byte_valid[g_reg];

`ifdef HASH_ARB_TIMEOUT_EN
    assign timeout_hit = (wcnt_reg == TO_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            g_reg      <= '0;
            rr_reg     <= '0;
            grant_reg  <= '0;
            done_reg   <= '0;
            err_reg    <= '0;
            cnt_reg    <= '0;
            c_in_reg   <= '0;
            digest_reg <= '0;
            wcnt_reg   <= '0;
        end else begin
            done_reg <= '0;
            err_reg  <= '0;
            case (state_reg)
                IDLE: begin
                    if (arb_any) begin
                        g_reg     <= arb_idx;
                        grant_reg <= arb_grant;
                        c_in_reg  <= sel_len;
                        cnt_reg   <= sel_len;
                        state_reg <= (sel_len == '0) ? EMPTY : SEND;
                    end
                end
                EMPTY: begin
                    wcnt_reg  <= '0;
                    state_reg <= WAIT;
                end
                SEND: begin
                    if (xfer) begin
                        cnt_reg <= cnt_reg - 1'b1;
                        if (cnt_reg == LEN_W'(1)) begin
                            wcnt_reg  <= '0;
                            state_reg <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    // wcnt_reg == 0 marks the first WAIT cycle, where hash_ready
                    // may still belong to the previous job.
                    if (wcnt_reg != '0 && hash_ready) begin
                        digest_reg <= hash_digest;
                        done_reg   <= grant_reg;
                        state_reg  <= DONE;
                    end else if (timeout_hit) begin
                        err_reg   <= grant_reg;
                        state_reg <= DONE;
                    end else if (wcnt_reg != TO_W'(TIMEOUT_CYCLES)) begin
                        wcnt_reg <= wcnt_reg + 1'b1;
                    end
                end
                DONE: begin
                    grant_reg <= '0;
                    c_in_reg  <= '0;
                    rr_reg    <= (g_reg == IDX_W'(NREQ - 1)) ? '0 : g_reg + 1'b1;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign req_grant      = grant_reg;
    assign req_done       = done_reg;
    assign req_err        = err_reg;
    assign digest         = digest_reg;
    assign busy           = (state_reg != IDLE);
    assign hash_C_in      = c_in_reg;
    assign hash_M_valid   = (state_reg == EMPTY) || xfer;
    assign hash_M         = (state_reg == SEND) ? byte_arr[g_reg] : 8'h00;
    assign req_byte_ready = xfer ? grant_reg : '0;
endmodule

// File: tb/tb_hash_arbiter.sv
// Directed bench for hash_arbiter: behavioural requesters, a behavioural hash
// core, and a scoreboard of expected (requester, digest) pairs per completed job.
module tb_hash_arbiter;
    localparam int NREQ  = 4;
    localparam int LEN_W = 64;
    localparam logic [31:0] SEED = 32'h956F7883;

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*LEN_W-1:0] req_len;
    logic [NREQ*8-1:0]     req_byte;
    logic [NREQ-1:0]       req_byte_valid;
    logic [NREQ-1:0]       req_byte_ready;
    logic [NREQ-1:0]       req_grant;
    logic [NREQ-1:0]       req_done;
    logic [NREQ-1:0]       req_err;
    logic [31:0]           digest;
    logic                  busy;
    logic                  hash_M_valid;
    logic [LEN_W-1:0]      hash_C_in;
    logic [7:0]            hash_M;
    logic                  hash_ready;
    logic [31:0]           hash_digest;

    hash_arbiter #(
        .NREQ           (NREQ),
        .LEN_W          (LEN_W),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_len        (req_len),
        .req_byte       (req_byte),
        .req_byte_valid (req_byte_valid),
        .req_byte_ready (req_byte_ready),
        .req_grant      (req_grant),
        .req_done       (req_done),
        .req_err        (req_err),
        .digest         (digest),
        .busy           (busy),
        .hash_M_valid   (hash_M_valid),
        .hash_C_in      (hash_C_in),
        .hash_M         (hash_M),
        .hash_ready     (hash_ready),
        .hash_digest    (hash_digest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          idx;
        logic [31:0] dig;
    } exp_t;
    exp_t sb[$];

    // Requester-side message description (written by the main sequence only)
    int          flen  [NREQ];
    logic [7:0]  fbase [NREQ];
    bit          fgap  [NREQ];
    // Requester-side progress (written by the feeder only)
    int          fptr  [NREQ];
    int          fphase[NREQ];

    bit m_hold_low = 1'b0;

    // Monitor totals (written by the monitor only)
    int mv_total = 0;
    int rdy_total = 0;
    int overlap_cnt = 0;
    int stray_cnt = 0;
    int err_seen = 0;
    logic [LEN_W-1:0] last_cin = '0;
    int grant_log[$];

    function automatic logic [31:0] mix(input logic [31:0] h, input logic [7:0] b);
        return {h[26:0], h[31:27]} ^ (h + {24'h0, b});
    endfunction

    function automatic logic [31:0] exp_dig(input int len, input logic [7:0] base);
        logic [31:0] h;
        h = SEED;
        for (int k = 0; k < len; k++) h = mix(h, base + 8'(k));
        return h;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic start_job(input int i, input int len, input logic [7:0] base,
                             input bit gap, input bit push);
        flen[i]  = len;
        fbase[i] = base;
        fgap[i]  = gap;
        req_len[i*LEN_W +: LEN_W] = LEN_W'(len);
        req_valid[i] = 1'b1;
        if (push) sb.push_back('{i, exp_dig(len, base)});
        $display("job start: req=%0d len=%0d base=%0h gap=%0d", i, len, base, gap);
    endtask

    task automatic wait_grant(input int i, input int budget);
        bit found = 1'b0;
        for (int c = 0; c < budget && !found; c++) begin
            @(negedge clk);
            if (req_grant[i]) found = 1'b1;
        end
        chk($sformatf("grant req%0d", i), 64'(found), 64'd1);
    endtask

    task automatic wait_done(input string tag, input int budget, output logic [63:0] cin_done);
        bit   found = 1'b0;
        int   di = -1;
        exp_t e;
        cin_done = '0;
        for (int c = 0; c < budget && !found; c++) begin
            @(negedge clk);
            if (req_done != '0) found = 1'b1;
        end
        chk({tag, " done seen"}, 64'(found), 64'd1);
        if (found) begin
            cin_done = hash_C_in;
            for (int i = 0; i < NREQ; i++) if (req_done[i]) di = i;
            chk({tag, " done onehot"}, 64'($countones(req_done)), 64'd1);
            if (sb.size() == 0) begin
                chk({tag, " scoreboard entry"}, 64'd0, 64'd1);
            end else begin
                e = sb.pop_front();
                chk({tag, " idx"}, 64'(di), 64'(e.idx));
                chk({tag, " digest"}, 64'(digest), 64'(e.dig));
            end
            $display("job done: %s req=%0d digest=%08h", tag, di, digest);
            @(negedge clk);
            chk({tag, " done pulse width"}, 64'(req_done), 64'd0);
            chk({tag, " C_in cleared"}, hash_C_in, 64'd0);
        end
    endtask

    // Requesters: present bytes while granted, advance on each accepted byte.
    initial begin : feeder
        logic [NREQ-1:0] xfer;
        logic [NREQ-1:0] prev_grant;
        req_byte_valid = '0;
        req_byte       = '0;
        prev_grant     = '0;
        for (int i = 0; i < NREQ; i++) begin
            fptr[i]   = 0;
            fphase[i] = 0;
        end
        forever begin
            @(negedge clk);
            xfer = req_byte_valid & req_byte_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (req_grant[i] && !prev_grant[i]) begin
                    fptr[i]   = 0;
                    fphase[i] = 0;
                end else begin
                    if (xfer[i]) fptr[i]++;
                    fphase[i]++;
                end
                req_byte[i*8 +: 8] = fbase[i] + 8'(fptr[i]);
                req_byte_valid[i]  = req_grant[i] && (fptr[i] < flen[i]) &&
                                     (!fgap[i] || (fphase[i] % 3 == 0));
            end
            prev_grant = req_grant;
        end
    end

    // Behavioural hash core: folds bytes, raises hash_ready 3 cycles after
    // the last byte and holds it until the next message starts.
    initial begin : core_model
        bit          m_active;
        logic [31:0] m_acc;
        logic [63:0] m_cnt;
        int          m_lat;
        logic        mv;
        logic [7:0]  mb;
        logic [63:0] cin;
        hash_ready  = 1'b0;
        hash_digest = '0;
        m_active = 1'b0;
        m_acc    = '0;
        m_cnt    = '0;
        m_lat    = -1;
        forever begin
            @(negedge clk);
            mv  = hash_M_valid;
            mb  = hash_M;
            cin = hash_C_in;
            @(posedge clk);
            #1;
            if (!rst_n) begin
                hash_ready  = 1'b0;
                hash_digest = '0;
                m_active    = 1'b0;
                m_lat       = -1;
            end else if (mv) begin
                if (!m_active) begin
                    m_active   = 1'b1;
                    m_acc      = SEED;
                    m_cnt      = '0;
                    hash_ready = 1'b0;
                end
                if (cin == '0) begin
                    m_lat = 3;
                end else begin
                    m_acc = mix(m_acc, mb);
                    m_cnt++;
                    if (m_cnt == cin) m_lat = 3;
                end
            end else if (m_lat > 0) begin
                m_lat--;
            end else if (m_lat == 0) begin
                if (!m_hold_low) begin
                    hash_ready  = 1'b1;
                    hash_digest = m_acc;
                end
                m_active = 1'b0;
                m_lat    = -1;
            end
        end
    end

    initial begin : monitor
        logic [NREQ-1:0] prev_g;
        prev_g = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (!$onehot0(req_grant)) overlap_cnt++;
                if ((req_byte_ready & ~req_grant) != '0) stray_cnt++;
                if (req_err != '0) err_seen++;
                if (hash_M_valid) begin
                    mv_total++;
                    last_cin = hash_C_in;
                end
                rdy_total += $countones(req_byte_ready);
                if (prev_g == '0 && req_grant != '0) begin
                    for (int i = 0; i < NREQ; i++) if (req_grant[i]) grant_log.push_back(i);
                end
            end
            prev_g = req_grant;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        int          mv0, r0, n0, cyc;
        bit          found;
        logic [63:0] cin_done;
        logic [31:0] prev_dig;

        rst_n     = 1'b0;
        req_valid = '0;
        req_len   = '0;
        for (int i = 0; i < NREQ; i++) begin
            flen[i]  = 0;
            fbase[i] = 8'h00;
            fgap[i]  = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset grant",   64'(req_grant), 64'd0);
        chk("reset done",    64'(req_done), 64'd0);
        chk("reset err",     64'(req_err), 64'd0);
        chk("reset ready",   64'(req_byte_ready), 64'd0);
        chk("reset digest",  64'(digest), 64'd0);
        chk("reset busy",    64'(busy), 64'd0);
        chk("reset M_valid", 64'(hash_M_valid), 64'd0);
        chk("reset C_in",    hash_C_in, 64'd0);
        chk("reset M",       64'(hash_M), 64'd0);
        rst_n = 1'b1;

        // Empty message
        mv0 = mv_total; r0 = rdy_total;
        start_job(0, 0, 8'h10, 1'b0, 1'b1);
        wait_grant(0, 10);
        req_valid[0] = 1'b0;
        chk("empty busy", 64'(busy), 64'd1);
        wait_done("empty", 100, cin_done);
        chk("empty M_valid pulses", 64'(mv_total - mv0), 64'd1);
        chk("empty byte_ready", 64'(rdy_total - r0), 64'd0);
        chk("empty C_in at pulse", last_cin, 64'd0);
        chk("empty digest const", 64'(digest), 64'(SEED));

        // Single byte "A"
        mv0 = mv_total; r0 = rdy_total;
        start_job(1, 1, 8'd65, 1'b0, 1'b1);
        wait_grant(1, 10);
        req_valid[1] = 1'b0;
        chk("single C_in at grant", hash_C_in, 64'd1);
        wait_done("single", 100, cin_done);
        chk("single C_in at done", cin_done, 64'd1);
        chk("single transfers", 64'(rdy_total - r0), 64'd1);
        chk("single M_valid", 64'(mv_total - mv0), 64'd1);

        // Gapped 156-byte stream
        r0 = rdy_total;
        start_job(2, 156, 8'h00, 1'b1, 1'b1);
        wait_grant(2, 10);
        req_valid[2] = 1'b0;
        wait_done("gapped", 3000, cin_done);
        chk("gapped transfers", 64'(rdy_total - r0), 64'd156);
        chk("gapped C_in at done", cin_done, 64'd156);

        // Move the pointer back to 0
        start_job(3, 2, 8'h30, 1'b0, 1'b1);
        wait_grant(3, 10);
        req_valid[3] = 1'b0;
        wait_done("align", 200, cin_done);

        // Round-robin, all requesters pending
        n0 = grant_log.size();
        for (int i = 0; i < NREQ; i++) start_job(i, 3, 8'h50 + 8'(i * 16), 1'b0, 1'b1);
        sb.push_back('{0, exp_dig(3, 8'h50)});
        for (int k = 0; k < NREQ; k++) wait_done($sformatf("rr%0d", k), 200, cin_done);
        req_valid = 4'b0001;
        wait_grant(0, 10);
        req_valid = '0;
        wait_done("rr4", 200, cin_done);
        chk("rr grant count", 64'(grant_log.size() - n0), 64'd5);
        if (grant_log.size() - n0 == 5) begin
            for (int k = 0; k < 5; k++)
                chk($sformatf("rr order %0d", k), 64'(grant_log[n0 + k]), 64'(k % NREQ));
        end

        // Reset in the middle of a 255-byte job
        start_job(1, 255, 8'h40, 1'b0, 1'b0);
        wait_grant(1, 10);
        req_valid[1] = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 400 && !found; c++) begin
            @(negedge clk);
            if (fptr[1] >= 100) found = 1'b1;
        end
        chk("reach byte 100", 64'(found), 64'd1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midreset grant",   64'(req_grant), 64'd0);
        chk("midreset ready",   64'(req_byte_ready), 64'd0);
        chk("midreset M_valid", 64'(hash_M_valid), 64'd0);
        chk("midreset C_in",    hash_C_in, 64'd0);
        chk("midreset busy",    64'(busy), 64'd0);
        chk("midreset digest",  64'(digest), 64'd0);
        $display("reset asserted mid-job at byte %0d", fptr[1]);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        start_job(2, 5, 8'h77, 1'b0, 1'b1);
        wait_grant(2, 10);
        req_valid[2] = 1'b0;
        wait_done("post-reset", 200, cin_done);

`ifdef HASH_ARB_TIMEOUT_EN
        // Core never answers: requester 0 times out, requester 1 is next
        prev_dig   = digest;
        m_hold_low = 1'b1;
        start_job(0, 2, 8'h20, 1'b0, 1'b0);
        start_job(1, 4, 8'h31, 1'b0, 1'b1);
        wait_grant(0, 10);
        req_valid[0] = 1'b0;
        found = 1'b0;
        cyc = 0;
        for (int c = 1; c < 200 && !found; c++) begin
            @(negedge clk);
            if (req_err != '0) begin
                found = 1'b1;
                cyc = c;
            end
        end
        chk("timeout err seen", 64'(found), 64'd1);
        chk("timeout err req0", 64'(req_err), 64'd1);
        chk("timeout no done", 64'(req_done), 64'd0);
        chk("timeout latency", 64'(cyc), 64'd66);
        chk("timeout digest kept", 64'(digest), 64'(prev_dig));
        $display("timeout: req_err after %0d cycles", cyc);
        m_hold_low = 1'b0;
        wait_grant(1, 10);
        req_valid[1] = 1'b0;
        wait_done("after-timeout", 200, cin_done);
`else
        prev_dig = digest;
        cyc = 0;
        chk("err never pulsed", 64'(err_seen), 64'd0);
        chk("digest stable idle", 64'(digest), 64'(prev_dig + 32'(cyc)));
`endif

        chk("grant overlap", 64'(overlap_cnt), 64'd0);
        chk("stray byte_ready", 64'(stray_cnt), 64'd0);
        chk("scoreboard drained", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
